// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel clock-enable generator with lock qualification and glitch-free divisor reload.
// Optional feature macro: CLKGEN_PHASE_SYNC_EN adds sync_i, which zeroes all counters to phase-align the channels.
module clk_enable_gen #(
    parameter int                        NUM_CH      = 2,
    parameter int                        DIV_W       = 16,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT    = {16'd50, 16'd10},
    parameter int                        LOCK_CYCLES = 16,
    parameter int                        CH_W        = 1
) (
    input  logic              refclk,
    input  logic              rst,
`ifdef CLKGEN_PHASE_SYNC_EN
    input  logic              sync_i,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic              locked
);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             ready_q, ready_d;
    logic             pend_q, pend_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [DIV_W-1:0] cnt_q [NUM_CH];
    logic [DIV_W-1:0] cnt_d [NUM_CH];
    logic [DIV_W-1:0] div_q [NUM_CH];
    logic [DIV_W-1:0] div_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d, clk_q, clk_d;
    logic [NUM_CH-1:0] en, wrap, sel, apply, store;
    logic             accept, sync;

`ifdef CLKGEN_PHASE_SYNC_EN
    assign sync = sync_i && locked_q;
`else
    assign sync = 1'b0;
`endif

    assign accept    = cfg_valid && ready_q;
    assign cfg_ready = ready_q;
    assign locked    = locked_q;
    assign tick_o    = tick_q;
    assign clk_o     = clk_q;

    // Settle counter: locked rises on the LOCK_CYCLES-th edge after reset release and then holds.
    always_comb begin
        lock_cnt_d = locked_q ? lock_cnt_q : lock_cnt_q + LW'(1);
        locked_d   = locked_q || (lock_cnt_q == LW'(LOCK_CYCLES - 1));
    end

    // Per-channel next state: wraps use the old divisor, so a reload only lands on a period boundary.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            en[i]    = div_q[i] != '0;
            wrap[i]  = locked_q && en[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
            sel[i]   = accept && (cfg_ch == CH_W'(i));
            store[i] = sel[i] && en[i];
            apply[i] = pend_q && (pend_ch_q == CH_W'(i)) && (wrap[i] || sync);
            div_d[i] = (sel[i] && !en[i]) ? cfg_div : apply[i] ? pend_div_q : div_q[i];
            cnt_d[i] = (!locked_q || !en[i] || wrap[i] || sync) ? '0 : cnt_q[i] + DIV_W'(1);
            tick_d[i] = wrap[i] && !sync;
            clk_d[i]  = locked_d && ((div_d[i] == DIV_W'(1)) || (cnt_d[i] < (div_d[i] >> 1)));
        end
    end

    // Single in-flight update slot; ready reopens the cycle after the pending value is applied.
    always_comb begin
        pend_d     = (|store) || (pend_q && !(|apply));
        pend_ch_d  = (|store) ? cfg_ch : pend_ch_q;
        pend_div_d = (|store) ? cfg_div : pend_div_q;
        ready_d    = locked_d && !pend_d;
    end

    // State registers; reset restores the power-on divisors and drops every output.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            tick_q     <= '0;
            clk_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
            end
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            ready_q    <= ready_d;
            pend_q     <= pend_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            tick_q     <= tick_d;
            clk_q      <= clk_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
        end
    end
endmodule
